// File: rtl/tag_pool.sv
// tag_pool: FIFO free-list of NumTags tags with NumFreePorts return ports.
// Tags are handed out from the head and returned at the tail, so the least
// recently freed tag is reused first. All outputs come from registered state.
// Optional feature: define TAG_POOL_CHECK_EN to track which tags are in the
// pool. With it, double frees and duplicate same-cycle frees are dropped and
// raise the sticky error_o.
module tag_pool #(
    parameter int NumTags      = 8,
    parameter int NumFreePorts = 2,
    localparam int TagWidth    = $clog2(NumTags),
    localparam int CountWidth  = $clog2(NumTags + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NumFreePorts-1:0]                free_i,
    input  logic [NumFreePorts-1:0][TagWidth-1:0]  tag_i,
    input  logic                                   get_i,
    output logic                                   valid_o,
    output logic [TagWidth-1:0]                    tag_o,
    output logic [CountWidth-1:0]                  num_free_o,
    output logic                                   error_o
);

    logic [NumTags-1:0][TagWidth-1:0]      mem;
    logic [TagWidth-1:0]                   head_q, tail_q;
    logic [CountWidth-1:0]                 count_q;
    logic                                  get_ok;
    logic [NumFreePorts-1:0]               accept;
    logic [NumFreePorts-1:0]               bad;
    logic [NumFreePorts-1:0][TagWidth-1:0] wr_idx;
    int                                    n_acc;

    // Pointer arithmetic modulo NumTags (NumTags need not be a power of two).
    function automatic logic [TagWidth-1:0] wrap_add(input logic [TagWidth-1:0] base,
                                                     input int off);
        int s;
        s = int'(base) + off;
        return TagWidth'(s % NumTags);
    endfunction

`ifdef TAG_POOL_CHECK_EN
    logic [NumTags-1:0] in_pool;
    logic               err_q;
`endif

    assign valid_o    = (count_q != '0);
    assign tag_o      = mem[head_q];
    assign num_free_o = count_q;
    assign get_ok     = get_i && valid_o;

    // Decide which frees are accepted and compact them onto tail, tail+1, ...
    always_comb begin
        accept = '0;
        bad    = '0;
        wr_idx = '0;
        n_acc  = 0;
        for (int p = 0; p < NumFreePorts; p++) begin
            logic legal;
            legal = free_i[p];
`ifdef TAG_POOL_CHECK_EN
            if (int'(tag_i[p]) >= NumTags || in_pool[tag_i[p]]) legal = 1'b0;
            for (int q = 0; q < p; q++)
                if (free_i[q] && tag_i[q] == tag_i[p]) legal = 1'b0;
`endif
            accept[p] = legal;
            bad[p]    = free_i[p] && !legal;
            wr_idx[p] = wrap_add(tail_q, n_acc);
            if (legal) n_acc = n_acc + 1;
        end
    end

    // Ring storage, pointers and occupancy; flush restores the reset image.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < NumTags; i++) mem[i] <= TagWidth'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CountWidth'(NumTags);
        end else begin
            for (int p = 0; p < NumFreePorts; p++)
                if (accept[p]) mem[wr_idx[p]] <= tag_i[p];
            if (get_ok) head_q <= wrap_add(head_q, 1);
            tail_q  <= wrap_add(tail_q, n_acc);
            count_q <= CountWidth'(int'(count_q) - int'(get_ok) + n_acc);
        end
    end

`ifdef TAG_POOL_CHECK_EN
    // In-pool bitmap and sticky error flag, both cleared by reset or flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            in_pool <= '1;
            err_q   <= 1'b0;
        end else begin
            if (get_ok) in_pool[tag_o] <= 1'b0;
            for (int p = 0; p < NumFreePorts; p++)
                if (accept[p]) in_pool[tag_i[p]] <= 1'b1;
            if (|bad) err_q <= 1'b1;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;

    // Without the bitmap an illegal free can only be caught as an overflow.
    always @(posedge clk_i) begin
        if (!rst_i && !flush_i)
            assert (int'(count_q) - int'(get_ok) + n_acc <= NumTags && bad == '0);
    end
`endif

endmodule

// File: tb/tb_tag_pool.sv
// Bench for tag_pool: directed scenarios plus randomized traffic, checked
// against a queue-based model of the free list (front = next tag out).
module tb_tag_pool;
    localparam int NT  = 8;
    localparam int NFP = 2;
    localparam int TW  = 3;
    localparam int CW  = 4;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic [NFP-1:0]          free_i;
    logic [NFP-1:0][TW-1:0]  tag_i;
    logic                    get_i;
    logic                    valid_o;
    logic [TW-1:0]           tag_o;
    logic [CW-1:0]           num_free_o;
    logic                    error_o;

    int ncmp  = 0;
    int nfail = 0;
    int q[$];     // tags in the pool, in hand-out order
    int held[$];  // tags currently allocated to the bench
    bit exp_err;

    tag_pool #(.NumTags(NT), .NumFreePorts(NFP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .free_i(free_i),
        .tag_i(tag_i), .get_i(get_i), .valid_o(valid_o), .tag_o(tag_o),
        .num_free_o(num_free_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        held.delete();
        for (int i = 0; i < NT; i++) q.push_back(i);
        exp_err = 1'b0;
    endfunction

    function automatic void drop_held(input int t);
        for (int i = 0; i < held.size(); i++)
            if (held[i] == t) begin
                held.delete(i);
                return;
            end
    endfunction

    task automatic check_state();
        chk("valid_o", valid_o, q.size() != 0);
        chk("num_free_o", num_free_o, q.size());
        if (q.size() != 0) chk("tag_o", tag_o, q[0]);
        chk("error_o", error_o, exp_err);
    endtask

    // One clock with the given inputs, then model update and full check.
    task automatic cycle(input bit g, input bit [1:0] fm, input int t0, input int t1, input bit fl);
        int tv[2];
        int acc[$];
        tv = '{t0, t1};
        get_i = g; free_i = fm; tag_i[0] = TW'(t0); tag_i[1] = TW'(t1); flush_i = fl;
        @(posedge clk_i); #1;
        if (fl) model_reset();
        else begin
            for (int p = 0; p < NFP; p++) begin
                if (fm[p]) begin
                    bit ok = 1'b1;
`ifdef TAG_POOL_CHECK_EN
                    foreach (q[i]) if (q[i] == tv[p]) ok = 1'b0;
                    foreach (acc[i]) if (acc[i] == tv[p]) ok = 1'b0;
`endif
                    if (ok) acc.push_back(tv[p]);
                    else exp_err = 1'b1;
                end
            end
            if (g && q.size() != 0) held.push_back(q.pop_front());
            foreach (acc[i]) begin
                q.push_back(acc[i]);
                drop_held(acc[i]);
            end
        end
        get_i = 1'b0; free_i = '0; flush_i = 1'b0;
        check_state();
    endtask

    initial begin
        int k, i0, i1, t0, t1;
        bit [1:0] fm;
        rst_i = 1'b1; flush_i = 1'b0; get_i = 1'b0; free_i = '0; tag_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 check_state();
        @(negedge clk_i) rst_i = 1'b0;
        @(posedge clk_i); #1 check_state();

        // Eight gets hand out 0..7 in order, then the pool is empty.
        for (int i = 0; i < NT; i++) begin
            chk("seq_tag", tag_o, i);
            cycle(1, 2'b00, 0, 0, 0);
        end
        chk("empty_valid", valid_o, 0);
        chk("empty_count", num_free_o, 0);
        cycle(1, 2'b00, 0, 0, 0);  // get on empty pool is ignored

        // Two frees into an empty pool: port 0 goes first.
        cycle(0, 2'b11, 5, 2, 0);
        chk("refill_tag0", tag_o, 5);
        chk("refill_count", num_free_o, 2);
        cycle(1, 2'b00, 0, 0, 0);
        chk("refill_tag1", tag_o, 2);
        cycle(1, 2'b00, 0, 0, 0);

        // Get and free together at occupancy 3 keep the count steady.
        cycle(0, 2'b11, 0, 1, 0);
        cycle(0, 2'b01, 3, 0, 0);
        cycle(1, 2'b01, 4, 0, 0);
        chk("getfree_count", num_free_o, 3);
        chk("getfree_head", tag_o, 1);
        cycle(1, 2'b00, 0, 0, 0);
        cycle(1, 2'b00, 0, 0, 0);
        chk("getfree_tail", tag_o, 4);

        // Wrap: flush, allocate all, free all in pairs, then random traffic.
        cycle(0, 2'b00, 0, 0, 1);
        repeat (NT) cycle(1, 2'b00, 0, 0, 0);
        for (int i = 0; i < NT / 2; i++) cycle(0, 2'b11, held[1], held[0], 0);
        for (int n = 0; n < 500; n++) begin
            k = $urandom_range(0, held.size() >= 2 ? 2 : held.size());
            fm = 2'b00; t0 = 0; t1 = 0;
            if (k >= 1) begin
                i0 = $urandom_range(0, held.size() - 1);
                t0 = held[i0];
            end
            if (k == 2) begin
                i1 = (i0 + 1 + $urandom_range(0, held.size() - 2)) % held.size();
                t1 = held[i1];
                fm = 2'b11;
            end else if (k == 1) begin
                if ($urandom_range(0, 1) == 1) begin fm = 2'b10; t1 = t0; end
                else fm = 2'b01;
            end
            cycle($urandom_range(0, 2) != 0, fm, t0, t1, $urandom_range(0, 63) == 0);
        end

        // Flush wins over same-cycle get and frees.
        cycle(0, 2'b00, 0, 0, 1);
        repeat (3) cycle(1, 2'b00, 0, 0, 0);
        cycle(1, 2'b11, held[0], held[1], 1);
        chk("flush_count", num_free_o, NT);
        chk("flush_tag", tag_o, 0);

        // Reset mid-operation drops allocations and the pending free.
        repeat (3) cycle(1, 2'b00, 0, 0, 0);
        get_i = 1'b1; free_i = 2'b01; tag_i[0] = TW'(held[0]);
        rst_i = 1'b1;
        #1 model_reset();
        check_state();
        @(posedge clk_i); #1 check_state();
        @(negedge clk_i) begin rst_i = 1'b0; get_i = 1'b0; free_i = '0; end
        @(posedge clk_i); #1 check_state();

`ifdef TAG_POOL_CHECK_EN
        // Double free of tag 3 is dropped and sticks until flush.
        cycle(0, 2'b01, 3, 0, 0);
        chk("dbl_err", error_o, 1);
        chk("dbl_count", num_free_o, NT);
        cycle(0, 2'b00, 0, 0, 1);
        chk("flush_err", error_o, 0);
        // Same tag on both ports: port 1 loses.
        cycle(1, 2'b00, 0, 0, 0);
        cycle(0, 2'b11, 0, 0, 0);
        chk("dup_err", error_o, 1);
        chk("dup_count", num_free_o, NT);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
